// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
//   Byte-push and status bundle for the UART transmit path.
//   master : upstream byte source (rfifo drain / cmd_decode)
//   slave  : uart_tx_fifo
//   Signals:
//     tx_data_in  [7:0] byte to queue
//     tx_wr_en          push tx_data_in this cycle
//     tx_full           FIFO full, further pushes are dropped
//     tx_overflow       sticky, a push was dropped while full
//     tx_busy           frame in progress
//     tx_done           one-cycle pulse on the last cycle of each stop bit
//     rs232_tx          serial line, idle high
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;
   logic [7:0] tx_data_in;
   logic       tx_wr_en;
   logic       tx_full;
   logic       tx_overflow;
   logic       tx_busy;
   logic       tx_done;
   logic       rs232_tx;

   modport master (
      output tx_data_in,
      output tx_wr_en,
      input  tx_full,
      input  tx_overflow,
      input  tx_busy,
      input  tx_done,
      input  rs232_tx
   );

   modport slave (
      input  tx_data_in,
      input  tx_wr_en,
      output tx_full,
      output tx_overflow,
      output tx_busy,
      output tx_done,
      output rs232_tx
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART 8N1 transmitter fed by a 2^FIFO_AW byte FIFO. Bytes are sent
//   LSB-first, BAUD_CNT sclk cycles per bit, frames back-to-back while
//   bytes remain queued.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit (8E1, 11 bit times per frame).
//
//   Ports:
//     sclk   system clock
//     s_rst  asynchronous active-high reset
//     bus    uart_tx_fifo_if.slave (push side, status flags, rs232_tx)
//
//   FSM states:
//     state  | meaning
//     IDLE   | line high, waiting for a queued byte
//     START  | start bit (line low)
//     DATA   | 8 data bits, LSB first
//     PARITY | even parity bit (UART_TX_PARITY_EN only)
//     STOP   | stop bit (line high), tx_done on its last cycle
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int BAUD_CNT = 5208,
   parameter int FIFO_AW  = 4
) (
   input  logic            sclk,
   input  logic            s_rst,
   uart_tx_fifo_if.slave   bus
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
   localparam logic [BW-1:0]      BAUD_LAST = BW'(BAUD_CNT - 1);
   localparam logic [BW-1:0]      BAUD_PRE  = BW'(BAUD_CNT - 2);
   localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      , PARITY = 3'd4
`endif
   } state_t;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               overflow_q;

   state_t             state;
   logic [BW-1:0]      baud_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift_reg;
   logic               tx_line;
   logic               busy_q;
   logic               done_q;
`ifdef UART_TX_PARITY_EN
   logic               parity_bit;
`endif

   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               bit_end;
   logic [7:0]         head;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign push    = bus.tx_wr_en && !full;
   assign bit_end = (baud_cnt == BAUD_LAST);
   assign head    = mem[rd_ptr];
   // The FSM takes a byte either from IDLE or on the last stop cycle, which
   // is what makes consecutive frames gap-free.
   assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));

   assign bus.tx_full     = full;
   assign bus.tx_overflow = overflow_q;
   assign bus.tx_busy     = busy_q;
   assign bus.tx_done     = done_q;
   assign bus.rs232_tx    = tx_line;

   always_ff @(posedge sclk) begin
      if (push) begin
         mem[wr_ptr] <= bus.tx_data_in;
      end
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A pop in the same cycle does not rescue a push made while full.
         if (bus.tx_wr_en && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         tx_line    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (pop) begin
                  shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^head;
`endif
                  tx_line    <= 1'b0;
                  busy_q     <= 1'b1;
                  state      <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  baud_cnt  <= '0;
                  bit_cnt   <= '0;
                  tx_line   <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  state     <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx_line <= parity_bit;
                     state   <= PARITY;
`else
                     tx_line <= 1'b1;
                     state   <= STOP;
`endif
                  end else begin
                     tx_line   <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx_line  <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
                     parity_bit <= ^head;
`endif
                     tx_line    <= 1'b0;
                     state      <= START;
                  end else begin
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
                  // Registered pulse: raised one cycle early so it lands on
                  // the final stop cycle.
                  if (baud_cnt == BAUD_PRE) begin
                     done_q <= 1'b1;
                  end
               end
            end

            default: begin
               busy_q  <= 1'b0;
               tx_line <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
